// File: rtl/aryth_operand_sequencer.sv
// rtl/aryth_operand_sequencer.sv - byte-serial opcode/operand loader and result streamer for the arithmetic core
// Optional ARYTH_CHKSUM_EN appends an XOR checksum byte of the input frame to the result stream.
module aryth_operand_sequencer #(
    parameter int WIDTH = 16,
    parameter int SYNC  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         ui_in,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic [7:0]         uo_out,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [3:0]         opcode,
    output logic [WIDTH-1:0]   operand_a,
    output logic [WIDTH-1:0]   operand_b,
    input  logic               res_valid,
    input  logic [2*WIDTH-1:0] res_data
);
    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(2 * NB + 1);
`ifdef ARYTH_CHKSUM_EN
    localparam int RB = 2 * NB + 1;
`else
    localparam int RB = 2 * NB;
`endif
    localparam logic [CW-1:0] LAST_OP = CW'(NB - 1);
    localparam logic [CW-1:0] LAST_RD = CW'(RB - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_READ   = 3'd5;

    logic [2:0]         state;
    logic [CW-1:0]      cnt;
    logic [SYNC-1:0]    sync_q;
    logic               prev_q;
    logic               stb;
    logic [2*WIDTH-1:0] result;
    logic [7:0]         res_byte;
    logic               unused_bits;

    assign unused_bits = &{1'b0, uio_in[7:1]};

    // The strobe pin is asynchronous; only a synchronized rising edge counts as a byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], uio_in[0]};
            prev_q <= sync_q[SYNC-1];
        end
    end

    assign stb = ena & sync_q[SYNC-1] & ~prev_q;

`ifdef ARYTH_CHKSUM_EN
    logic [7:0] chksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum <= 8'h00;
        end else if (state == S_IDLE) begin
            chksum <= stb ? ui_in : 8'h00;
        end else if (stb && (state == S_LOAD_A || state == S_LOAD_B)) begin
            chksum <= chksum ^ ui_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            opcode    <= 4'h0;
            operand_a <= '0;
            operand_b <= '0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE: if (stb) begin
                    opcode <= ui_in[3:0];
                    cnt    <= '0;
                    state  <= S_LOAD_A;
                end
                S_LOAD_A: if (stb) begin
                    for (int i = 0; i < NB; i++)
                        if (cnt == CW'(i)) operand_a[i*8 +: 8] <= ui_in;
                    if (cnt == LAST_OP) begin
                        cnt   <= '0;
                        state <= S_LOAD_B;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOAD_B: if (stb) begin
                    for (int i = 0; i < NB; i++)
                        if (cnt == CW'(i)) operand_b[i*8 +: 8] <= ui_in;
                    if (cnt == LAST_OP) begin
                        cnt   <= '0;
                        state <= S_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ISSUE: if (op_ready) state <= S_WAIT;
                S_WAIT: if (res_valid) begin
                    result <= res_data;
                    cnt    <= '0;
                    state  <= S_READ;
                end
                S_READ: if (stb) begin
                    if (cnt == LAST_RD) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        res_byte = 8'h00;
        for (int i = 0; i < 2 * NB; i++)
            if (cnt == CW'(i)) res_byte = result[i*8 +: 8];
`ifdef ARYTH_CHKSUM_EN
        if (cnt == CW'(2 * NB)) res_byte = chksum;
`endif
    end

    assign op_valid = (state == S_ISSUE);
    assign uo_out   = (state == S_READ) ? res_byte : 8'h00;
    assign uio_out  = {5'b0, (state == S_READ),
                       (state == S_LOAD_A || state == S_LOAD_B || state == S_ISSUE || state == S_WAIT),
                       1'b0};
    assign uio_oe   = 8'b0000_0110;
endmodule

// File: tb/tb_aryth_operand_sequencer.sv
// tb/tb_aryth_operand_sequencer.sv - directed self-checking bench for aryth_operand_sequencer
module tb_aryth_operand_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  uio_in = 8'h00;
    logic [7:0]  uio_out, uio_oe, uo_out;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [3:0]  opcode;
    logic [15:0] operand_a, operand_b;
    logic        res_valid;
    logic [31:0] res_data;

    int checks = 0;
    int errors = 0;
    int op_pulses = 0;

    aryth_operand_sequencer #(.WIDTH(16), .SYNC(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out),
        .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .res_valid(res_valid), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Stub core: result A+B one cycle after the handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= 32'h0;
        end else begin
            res_valid <= op_valid & op_ready;
            res_data  <= {16'h0, operand_a} + {16'h0, operand_b};
        end
    end

    always @(posedge clk) if (op_valid && op_ready) op_pulses++;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ui_in = b;
        uio_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uio_out[2]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got %h exp 00", uo_out); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h exp 00", uio_out); end
        checks++; if (uio_oe !== 8'h06) begin errors++; $display("FAIL reset_uio_oe got %h exp 06", uio_oe); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b exp 0", op_valid); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame;
        bit ok;
        logic [7:0] exp_rd [5] = '{8'h35, 8'h12, 8'h00, 8'h00, 8'h26};
        int n;
        op_pulses = 0;
        send_byte(8'h01);
        checks++; if (uio_out[1] !== 1'b1) begin errors++; $display("FAIL frame_busy_after_opcode got %b exp 1", uio_out[1]); end
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h01);
        checks++; if (uio_out[1] !== 1'b1 || uio_out[2] !== 1'b0) begin errors++; $display("FAIL frame_busy_loading got %b exp busy only", uio_out); end
        send_byte(8'h00);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_done_timeout got 0 exp done"); end
        checks++; if (opcode !== 4'h1) begin errors++; $display("FAIL frame_opcode got %h exp 1", opcode); end
        checks++; if (operand_a !== 16'h1234) begin errors++; $display("FAIL frame_operand_a got %h exp 1234", operand_a); end
        checks++; if (operand_b !== 16'h0001) begin errors++; $display("FAIL frame_operand_b got %h exp 0001", operand_b); end
        checks++; if (op_pulses != 1) begin errors++; $display("FAIL frame_op_pulses got %0d exp 1", op_pulses); end
        checks++; if (uio_out !== 8'h04) begin errors++; $display("FAIL frame_done_flags got %h exp 04", uio_out); end
`ifdef ARYTH_CHKSUM_EN
        n = 5;
`else
        n = 4;
`endif
        for (int i = 0; i < n; i++) begin
            checks++; if (uo_out !== exp_rd[i]) begin errors++; $display("FAIL frame_read_byte%0d got %h exp %h", i, uo_out, exp_rd[i]); end
            send_byte(8'h00);
        end
        checks++; if (uio_out !== 8'h00 || uo_out !== 8'h00) begin errors++; $display("FAIL frame_back_idle got %h/%h exp 00/00", uio_out, uo_out); end
    endtask

    task automatic test_stall;
        bit ok;
        logic [7:0] exp_rd [5] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFC};
        int n;
        op_ready = 1'b0;
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'h00);
        repeat (10) @(negedge clk);
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL stall_op_valid got %b exp 1", op_valid); end
        send_byte(8'hEE);
        checks++; if (op_valid !== 1'b1 || opcode !== 4'h3) begin errors++; $display("FAIL stall_ignore_stb got %b/%h exp 1/3", op_valid, opcode); end
        checks++; if (operand_a !== 16'h00AA || operand_b !== 16'h0055) begin errors++; $display("FAIL stall_operands got %h/%h exp 00aa/0055", operand_a, operand_b); end
        op_ready = 1'b1;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got 0 exp done"); end
        repeat (3) @(negedge clk);
`ifdef ARYTH_CHKSUM_EN
        n = 5;
`else
        n = 4;
`endif
        for (int i = 0; i < n; i++) begin
            checks++; if (uo_out !== exp_rd[i]) begin errors++; $display("FAIL stall_read_byte%0d got %h exp %h", i, uo_out, exp_rd[i]); end
            send_byte(8'h00);
        end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL stall_back_idle got %h exp 00", uio_out); end
    endtask

    task automatic test_ena_and_hold;
        ena = 1'b0;
        send_byte(8'h07);
        checks++; if (uio_out !== 8'h00 || opcode !== 4'h3) begin errors++; $display("FAIL ena_low_ignored got %h/%h exp 00/3", uio_out, opcode); end
        ena = 1'b1;
        @(negedge clk);
        ui_in = 8'h05;
        uio_in[0] = 1'b1;
        repeat (8) @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (opcode !== 4'h5 || uio_out[1] !== 1'b1) begin errors++; $display("FAIL hold_opcode got %h/%b exp 5/1", opcode, uio_out[1]); end
        send_byte(8'h10);
        send_byte(8'h00);
        checks++; if (operand_a !== 16'h0010) begin errors++; $display("FAIL hold_single_capture got %h exp 0010", operand_a); end
        ena = 1'b0;
        send_byte(8'h99);
        checks++; if (operand_b !== 16'h0055) begin errors++; $display("FAIL ena_low_freeze got %h exp 0055", operand_b); end
        ena = 1'b1;
    endtask

    task automatic test_mid_reset;
        bit ok;
        send_byte(8'h22);
        checks++; if (operand_b[7:0] !== 8'h22) begin errors++; $display("FAIL midrst_load_b got %h exp 22", operand_b[7:0]); end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++; if (uio_out !== 8'h00 || opcode !== 4'h0 || operand_a !== 16'h0 || operand_b !== 16'h0 || op_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_outputs got %h/%h/%h/%h exp all 0", uio_out, opcode, operand_a, operand_b); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h02);
        checks++; if (opcode !== 4'h2 || uio_out[1] !== 1'b1) begin errors++; $display("FAIL midrst_new_opcode got %h/%b exp 2/1", opcode, uio_out[1]); end
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h00);
        wait_done(ok);
        checks++; if (!ok || uo_out !== 8'h08) begin errors++; $display("FAIL midrst_result got %h exp 08", uo_out); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_ena_and_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
